iq_fifo: RTL and testbench

//  Parametrised decode-to-issue instruction queue between the ID and IS stages; replaces the single-entry latch.

---
 rtl/iq_fifo_pkg.sv | 17 +
 rtl/iq_fifo_ram.sv | 36 +++
 rtl/iq_fifo.sv | 116 +++++++++++
 tb/tb_iq_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iq_fifo_pkg.sv
// ---------------------------------------------------------------------------
// iq_fifo_pkg
//   Shared sizing for the decode-to-issue instruction queue.
//   DS_TO_IS_BUS_WD : width of one decoded bundle (ID -> IS bus)
//   IQ_DEPTH        : default queue depth
//   iq_cnt_wd()     : occupancy counter width able to hold 0..depth
// ---------------------------------------------------------------------------
package iq_fifo_pkg;

   localparam int DS_TO_IS_BUS_WD = 64;
   localparam int IQ_DEPTH        = 4;

   function automatic int iq_cnt_wd(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/iq_fifo_ram.sv
// ---------------------------------------------------------------------------
// iq_fifo_ram
//   DEPTH x DATA_WD register array, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
// Ports
//   clk       in   clock, rising edge
//   we_i      in   write enable
//   waddr_i   in   write address
//   wdata_i   in   write data
//   raddr_i   in   read address
//   rdata_o   out  read data (combinational)
// ---------------------------------------------------------------------------
module iq_fifo_ram
   import iq_fifo_pkg::*;
#(
   parameter int DATA_WD = DS_TO_IS_BUS_WD,
   parameter int DEPTH   = IQ_DEPTH,
   parameter int PTR_WD  = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [PTR_WD-1:0]  waddr_i,
   input  logic [DATA_WD-1:0] wdata_i,
   input  logic [PTR_WD-1:0]  raddr_i,
   output logic [DATA_WD-1:0] rdata_o
);

   logic [DATA_WD-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iq_fifo.sv
// ---------------------------------------------------------------------------
// iq_fifo
//   Decode-to-issue instruction queue. Buffers up to DEPTH bundles between
//   ID and IS with valid/allowin handshakes on both sides, honours hazard
//   stall/flush, optional empty-queue bypass and full-queue pass-through.
// Ports
//   clk, resetn      clock (rising) / async active-low reset
//   iq_flush         discard all contents (wins over everything)
//   iq_stall         inhibit dequeue
//   ds_to_iq_valid   ID presents a bundle on ds_to_iq_bus
//   iq_allowin       queue accepts a bundle this cycle
//   iq_to_is_valid   bundle available to IS on iq_to_is_bus
//   is_allowin       IS accepts a bundle this cycle
//   iq_count         occupancy; iq_empty / iq_full derived from it
// ---------------------------------------------------------------------------
module iq_fifo
   import iq_fifo_pkg::*;
#(
   parameter int DATA_WD   = DS_TO_IS_BUS_WD,
   parameter int DEPTH     = IQ_DEPTH,
   parameter bit BYPASS    = 1'b1,
   parameter bit FULL_PASS = 1'b0,
   parameter int CNT_WD    = iq_cnt_wd(DEPTH)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               iq_flush,
   input  logic               iq_stall,
   input  logic               ds_to_iq_valid,
   input  logic [DATA_WD-1:0] ds_to_iq_bus,
   output logic               iq_allowin,
   output logic               iq_to_is_valid,
   output logic [DATA_WD-1:0] iq_to_is_bus,
   input  logic               is_allowin,
   output logic [CNT_WD-1:0]  iq_count,
   output logic               iq_empty,
   output logic               iq_full
);

   localparam int PTR_WD = $clog2(DEPTH);

   logic [PTR_WD-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_WD-1:0]  count_q, count_d;
   logic [DATA_WD-1:0] head;
   logic               push, pop, bypass, wr_en, rd_adv;

   assign iq_empty = (count_q == CNT_WD'(0));
   assign iq_full  = (count_q == CNT_WD'(DEPTH));

   assign iq_to_is_valid = ~iq_flush & (~iq_empty | (BYPASS & ds_to_iq_valid));
   assign pop            = iq_to_is_valid & is_allowin & ~iq_stall;
   assign iq_allowin     = ~iq_full | (FULL_PASS & pop);
   assign push           = ds_to_iq_valid & iq_allowin & ~iq_flush;

   // An empty-queue pop can only be the bypassed input: it flows straight
   // through, so neither the array nor the pointers are touched.
   assign bypass = BYPASS & iq_empty & push & pop;
   assign wr_en  = push & ~bypass;
   assign rd_adv = pop & ~bypass;

   assign iq_to_is_bus = iq_empty ? ds_to_iq_bus : head;
   assign iq_count     = count_q;

   iq_fifo_ram #(
      .DATA_WD (DATA_WD),
      .DEPTH   (DEPTH),
      .PTR_WD  (PTR_WD)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (ds_to_iq_bus),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (iq_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_WD'(1);
         if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_WD'(1);
         if (wr_en && !rd_adv)      count_d = count_q + CNT_WD'(1);
         else if (!wr_en && rd_adv) count_d = count_q - CNT_WD'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Simulation-only invariants on handshake legality and pointer/count agreement.
   always @(posedge clk) begin
      if (resetn) begin
         assert (!(push && iq_full && !pop));
         assert (!(pop && iq_empty && !bypass));
         assert (count_q <= CNT_WD'(DEPTH));
         assert (iq_full || (PTR_WD'(count_q) == PTR_WD'(wr_ptr_q - rd_ptr_q)));
      end
   end

endmodule

// File: tb/tb_iq_fifo.sv
module tb_iq_fifo;

  localparam int DW = 64;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          iq_flush = 1'b0, iq_stall = 1'b0;
  logic          ds_valid = 1'b0, is_allowin = 1'b0;
  logic [DW-1:0] ds_bus = '0;

  // dut: BYPASS=1, FULL_PASS=0; dut_f: BYPASS=1, FULL_PASS=1 (same stimulus)
  logic          allowin, valid, empty, full;
  logic [DW-1:0] bus;
  logic [CW-1:0] count;
  logic          allowin_f, valid_f, empty_f, full_f;
  logic [DW-1:0] bus_f;
  logic [CW-1:0] count_f;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  always #5 clk = ~clk;

  iq_fifo #(.DATA_WD(DW), .DEPTH(4), .BYPASS(1'b1), .FULL_PASS(1'b0)) dut (
    .clk(clk), .resetn(resetn), .iq_flush(iq_flush), .iq_stall(iq_stall),
    .ds_to_iq_valid(ds_valid), .ds_to_iq_bus(ds_bus), .iq_allowin(allowin),
    .iq_to_is_valid(valid), .iq_to_is_bus(bus), .is_allowin(is_allowin),
    .iq_count(count), .iq_empty(empty), .iq_full(full));

  iq_fifo #(.DATA_WD(DW), .DEPTH(4), .BYPASS(1'b1), .FULL_PASS(1'b1)) dut_f (
    .clk(clk), .resetn(resetn), .iq_flush(iq_flush), .iq_stall(iq_stall),
    .ds_to_iq_valid(ds_valid), .ds_to_iq_bus(ds_bus), .iq_allowin(allowin_f),
    .iq_to_is_valid(valid_f), .iq_to_is_bus(bus_f), .is_allowin(is_allowin),
    .iq_count(count_f), .iq_empty(empty_f), .iq_full(full_f));

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    if (!done) begin
      fails++;
      $error("FAIL timeout: test sequence did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    // ---- 1: reset state, then idle after release
    tick(); tick();
    #1;
    chk("rst_allowin", allowin, 1'b1);
    chk("rst_valid", valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    resetn = 1'b1;
    tick(); tick(); tick();
    #1;
    chk("idle_allowin", allowin, 1'b1);
    chk("idle_valid", valid, 1'b0);
    chk("idle_count", count, 3'd0);
    chk("idle_empty", empty, 1'b1);

    // ---- 2: bypass on empty queue
    ds_valid = 1'b1; ds_bus = 64'hA5; is_allowin = 1'b1;
    #1;
    chk("byp_valid", valid, 1'b1);
    chk("byp_bus", bus, 64'hA5);
    tick();
    ds_valid = 1'b0;
    #1;
    chk("byp_count", count, 3'd0);
    chk("byp_empty", empty, 1'b1);
    chk("byp_valid_after", valid, 1'b0);

    // ---- 3: fill to full, then drain in order
    is_allowin = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ds_valid = 1'b1; ds_bus = 64'(i);
      tick();
    end
    ds_valid = 1'b0;
    #1;
    chk("fill_count", count, 3'd4);
    chk("fill_full", full, 1'b1);
    chk("fill_allowin", allowin, 1'b0);
    chk("fill_allowin_f", allowin_f, 1'b0);
    is_allowin = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_valid", valid, 1'b1);
      chk("drain_bus", bus, 64'(i));
      chk("drain_bus_f", bus_f, 64'(i));
      tick();
    end
    is_allowin = 1'b0;
    #1;
    chk("drain_empty", empty, 1'b1);
    chk("drain_count_f", count_f, 3'd0);

    // ---- 4: steady push & pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      ds_valid = 1'b1; ds_bus = 64'h10 + 64'(i);
      tick();
    end
    is_allowin = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ds_valid = 1'b1; ds_bus = 64'h12 + 64'(k);
      #1;
      chk("wrap_bus", bus, 64'h10 + 64'(k));
      chk("wrap_count", count, 3'd2);
      tick();
    end
    ds_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("wrap_tail", bus, 64'h1A + 64'(k));
      tick();
    end
    is_allowin = 1'b0;
    #1;
    chk("wrap_empty", empty, 1'b1);

    // ---- 5: stall holds head, then flush wins over stall and push
    for (int i = 0; i < 3; i++) begin
      ds_valid = 1'b1; ds_bus = 64'h21 + 64'(i);
      tick();
    end
    iq_stall = 1'b1; is_allowin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ds_bus = 64'h24 + 64'(i);
      #1;
      chk("stall_head", bus, 64'h21);
      chk("stall_valid", valid, 1'b1);
      tick();
    end
    #1;
    chk("stall_count", count, 3'd4);
    chk("stall_count_f", count_f, 3'd4);
    iq_flush = 1'b1; ds_bus = 64'h26;
    #1;
    chk("flush_valid", valid, 1'b0);
    chk("flush_valid_f", valid_f, 1'b0);
    tick();
    iq_flush = 1'b0; iq_stall = 1'b0; ds_valid = 1'b0; is_allowin = 1'b0;
    #1;
    chk("flush_count", count, 3'd0);
    chk("flush_empty", empty, 1'b1);
    chk("flush_allowin", allowin, 1'b1);
    ds_valid = 1'b1; ds_bus = 64'h30;
    tick();
    iq_flush = 1'b1; ds_bus = 64'h31;
    #1;
    chk("flush2_allowin", allowin, 1'b1);
    chk("flush2_valid", valid, 1'b0);
    tick();
    iq_flush = 1'b0; ds_valid = 1'b0;
    #1;
    chk("flush2_count", count, 3'd0);

    // ---- 6: full-queue pass-through vs none
    for (int i = 0; i < 4; i++) begin
      ds_valid = 1'b1; ds_bus = 64'h41 + 64'(i);
      tick();
    end
    ds_bus = 64'h45; is_allowin = 1'b1;
    #1;
    chk("fp_allowin_off", allowin, 1'b0);
    chk("fp_allowin_on", allowin_f, 1'b1);
    chk("fp_head", bus, 64'h41);
    chk("fp_head_f", bus_f, 64'h41);
    tick();
    ds_valid = 1'b0;
    #1;
    chk("fp_count_off", count, 3'd3);
    chk("fp_count_on", count_f, 3'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_order_f", bus_f, 64'h42 + 64'(k));
      if (k < 3) chk("fp_order", bus, 64'h42 + 64'(k));
      else       chk("fp_done_valid", valid, 1'b0);
      tick();
    end
    is_allowin = 1'b0;
    #1;
    chk("fp_empty_f", empty_f, 1'b1);

    // ---- reset mid-operation drops contents immediately
    ds_valid = 1'b1; ds_bus = 64'h55;
    tick(); tick();
    ds_valid = 1'b0;
    #1;
    chk("mid_count", count, 3'd2);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_count", count, 3'd0);
    chk("mid_rst_valid", valid, 1'b0);
    tick();
    resetn = 1'b1;
    tick();
    #1;
    chk("post_rst_empty", empty, 1'b1);
    chk("post_rst_allowin", allowin, 1'b1);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
